// File: rtl/nrisc_multiciclo.sv
// nrisc_multiciclo -- multi-cycle nRisc core with parametrised data/PC width.
//
// Executes the 8-bit nRisc instruction encoding (two registers r0/r1) as a
// FETCH/DECODE/EXEC/MEM/WB state machine. Instruction and data memories are
// reached through req/ack handshakes, so memories with wait states work.
//
// Parameters:
//   DATA_W  datapath, register and data-memory width (>= 5)
//   PC_W    program counter / instruction address width (>= 5)
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   imem_req/addr/rdata/ack instruction fetch handshake (addr = pc)
//   dmem_req/we/addr/wdata  data access request (addr = zext(imm4), wdata = ra)
//   dmem_rdata/ack          load data and access completion
//   halted                  core has executed HALT (only reset exits)
//   pc_out                  current program counter
//
// Optional feature, enabled by defining NRISC_RETIRE_EN:
//   retire   one-cycle pulse on the last cycle of each completed instruction
//   instret  32-bit retired-instruction counter (wraps)

module nrisc_multiciclo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PC_W   = 8
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [7:0]        imem_rdata,
    input  logic              imem_ack,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              halted,
    output logic [PC_W-1:0]   pc_out
`ifdef NRISC_RETIRE_EN
    ,
    output logic              retire,
    output logic [31:0]       instret
`endif
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD,
        OP_SUB,
        OP_ADDI,
        OP_LW,
        OP_SW,
        OP_BEQ,
        OP_J,
        OP_HALT
    } op_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;
    logic [DATA_W-1:0] r0_q, r0_d;
    logic [DATA_W-1:0] r1_q, r1_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              imem_req_q, imem_req_d;
    logic              dmem_req_q, dmem_req_d;
    logic              dmem_we_q, dmem_we_d;
    logic [DATA_W-1:0] dmem_addr_q, dmem_addr_d;
    logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;
    logic              halted_q, halted_d;
    logic              retire_c;

    op_t               op;
    logic              ra;
    logic              rb;
    logic [DATA_W-1:0] imm4_sx;
    logic [DATA_W-1:0] imm4_zx;
    logic [PC_W-1:0]   imm3_sx;
    logic [PC_W-1:0]   imm5_zx;

    always_comb begin
        op      = op_t'(ir_q[7:5]);
        ra      = ir_q[4];
        rb      = ir_q[3];
        imm4_sx = DATA_W'($signed(ir_q[3:0]));
        imm4_zx = DATA_W'(ir_q[3:0]);
        imm3_sx = PC_W'($signed(ir_q[2:0]));
        imm5_zx = PC_W'(ir_q[4:0]);

        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        r0_d     = r0_q;
        r1_d     = r1_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        retire_c = 1'b0;

        case (state_q)
            S_FETCH: begin
                // Ack only counts once our request is actually visible.
                if (imem_req_q && imem_ack) begin
                    ir_d    = imem_rdata;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = ra ? r1_q : r0_q;
                b_d     = rb ? r1_q : r0_q;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (op)
                    OP_ADD:  begin res_d = a_q + b_q;     state_d = S_WB; end
                    OP_SUB:  begin res_d = a_q - b_q;     state_d = S_WB; end
                    OP_ADDI: begin res_d = a_q + imm4_sx; state_d = S_WB; end
                    OP_LW:   state_d = S_MEM;
                    OP_SW:   state_d = S_MEM;
                    OP_BEQ: begin
                        // pc already points past the BEQ here.
                        if (a_q == b_q) pc_d = pc_q + imm3_sx;
                        state_d  = S_FETCH;
                        retire_c = 1'b1;
                    end
                    OP_J: begin
                        pc_d     = imm5_zx;
                        state_d  = S_FETCH;
                        retire_c = 1'b1;
                    end
                    OP_HALT: begin
                        state_d  = S_HALT;
                        retire_c = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                if (dmem_req_q && dmem_ack) begin
                    if (op == OP_LW) begin
                        res_d   = dmem_rdata;
                        state_d = S_WB;
                    end else begin
                        state_d  = S_FETCH;
                        retire_c = 1'b1;
                    end
                end
            end
            S_WB: begin
                if (ra) r1_d = res_q;
                else    r0_d = res_q;
                state_d  = S_FETCH;
                retire_c = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase

        // Request outputs are registered from the next state so they are
        // high from the first cycle of the state and held until ack.
        imem_req_d   = (state_d == S_FETCH);
        dmem_req_d   = (state_d == S_MEM);
        dmem_we_d    = (state_d == S_MEM) && (op == OP_SW);
        halted_d     = (state_d == S_HALT);
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        if (state_q == S_EXEC && state_d == S_MEM) begin
            dmem_addr_d  = imm4_zx;
            dmem_wdata_d = a_q;
        end
    end

`ifdef NRISC_RETIRE_EN
    logic [31:0] instret_q, instret_d;

    always_comb begin
        instret_d = instret_q + 32'(retire_c);
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_FETCH;
            pc_q         <= '0;
            ir_q         <= '0;
            r0_q         <= '0;
            r1_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            imem_req_q   <= 1'b0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            halted_q     <= 1'b0;
`ifdef NRISC_RETIRE_EN
            instret_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            r0_q         <= r0_d;
            r1_q         <= r1_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
            imem_req_q   <= imem_req_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            halted_q     <= halted_d;
`ifdef NRISC_RETIRE_EN
            instret_q    <= instret_d;
`endif
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign halted     = halted_q;
    assign pc_out     = pc_q;

`ifdef NRISC_RETIRE_EN
    // retire is combinational: a store completes on the ack cycle itself.
    assign retire  = retire_c;
    assign instret = instret_q;
`else
    logic unused_retire;
    assign unused_retire = retire_c;
`endif

endmodule

// File: tb/tb_nrisc_multiciclo.sv
// Directed testbench for nrisc_multiciclo (8-bit and 16-bit data instances).
module tb_nrisc_multiciclo;

    logic        clock;
    logic        reset;
    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, halted;
    logic [7:0]  imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, pc_out;
`ifdef NRISC_RETIRE_EN
    logic        retire, retire16, prev_retire;
    logic [31:0] instret, instret16;
`endif

    logic        imem16_req, imem16_ack, dmem16_req, dmem16_we, dmem16_ack, halted16;
    logic [7:0]  imem16_addr, imem16_rdata, pc16_out;
    logic [15:0] dmem16_addr, dmem16_wdata, dmem16_rdata, st16;

    logic [7:0]  rom   [0:255];
    logic [7:0]  rom16 [0:255];
    logic [7:0]  dram  [0:15];
    logic [7:0]  trace [0:31];
    logic [7:0]  daddr0;
    logic        dwe0;
    int          ntr, icnt, dcnt, imem_wait, dmem_wait, cyc;
    int          n_cmp, n_err;

    nrisc_multiciclo #(.DATA_W(8), .PC_W(8)) u_dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .halted(halted), .pc_out(pc_out)
`ifdef NRISC_RETIRE_EN
        , .retire(retire), .instret(instret)
`endif
    );

    nrisc_multiciclo #(.DATA_W(16), .PC_W(8)) u_dut16 (
        .clock(clock), .reset(reset),
        .imem_req(imem16_req), .imem_addr(imem16_addr), .imem_rdata(imem16_rdata), .imem_ack(imem16_ack),
        .dmem_req(dmem16_req), .dmem_we(dmem16_we), .dmem_addr(dmem16_addr), .dmem_wdata(dmem16_wdata),
        .dmem_rdata(dmem16_rdata), .dmem_ack(dmem16_ack), .halted(halted16), .pc_out(pc16_out)
`ifdef NRISC_RETIRE_EN
        , .retire(retire16), .instret(instret16)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: wait for the falling edge, then play both memories.
    task automatic tick();
        @(negedge clock);
        if (imem_req) begin
            imem_ack = (icnt == imem_wait);
            if (imem_ack) begin
                imem_rdata = rom[imem_addr];
                if (ntr < 32) trace[ntr] = imem_addr;
                ntr++;
            end
            icnt++;
        end else begin
            imem_ack = 1'b0;
            icnt     = 0;
        end
        if (dmem_req) begin
            if (dcnt == 0) begin
                daddr0 = dmem_addr;
                dwe0   = dmem_we;
            end else begin
                chk("dmem_addr_stable", 32'(dmem_addr), 32'(daddr0));
                chk("dmem_we_stable", 32'(dmem_we), 32'(dwe0));
            end
            dmem_ack = (dcnt == dmem_wait);
            if (dmem_ack) begin
                if (dmem_we) dram[dmem_addr[3:0]] = dmem_wdata;
                else         dmem_rdata = dram[dmem_addr[3:0]];
            end
            dcnt++;
        end else begin
            dmem_ack = 1'b0;
            dcnt     = 0;
        end
        imem16_ack   = imem16_req;
        imem16_rdata = rom16[imem16_addr];
        dmem16_ack   = dmem16_req;
        if (dmem16_req && dmem16_we) st16 = dmem16_wdata;
`ifdef NRISC_RETIRE_EN
        if (retire) chk("retire_gap", 32'(prev_retire), 32'd0);
        prev_retire = retire;
`endif
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) rom[i] = 8'hE0;
        for (int i = 0; i < 16; i++) dram[i] = 8'hEE;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        ntr   = 0;
    endtask

    task automatic run(input int lim);
        cyc = 0;
        while (!halted && cyc < lim) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0; ntr = 0; icnt = 0; dcnt = 0;
        imem_wait = 0; dmem_wait = 0; st16 = '0;
        reset = 1'b1;
        imem_ack = 1'b0; imem_rdata = '0; dmem_ack = 1'b0; dmem_rdata = '0;
        imem16_ack = 1'b0; imem16_rdata = '0; dmem16_ack = 1'b0; dmem16_rdata = '0;
`ifdef NRISC_RETIRE_EN
        prev_retire = 1'b0;
`endif
        for (int i = 0; i < 256; i++) rom16[i] = 8'hE0;
        rom16[0] = 8'h48; rom16[1] = 8'h80;     // ADDI r0,-8 ; SW r0,0 ; HALT

        // Program A: ADDI r0,3; ADDI r1,-1; ADD r0,r1; HALT
        clear_mem();
        rom[0] = 8'h43; rom[1] = 8'h5F; rom[2] = 8'h08;
        do_reset();
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_dmem_we", 32'(dmem_we), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_pc_out", 32'(pc_out), 32'd0);
        chk("rst_dmem_addr", 32'(dmem_addr), 32'd0);
        chk("rst_dmem_wdata", 32'(dmem_wdata), 32'd0);
        tick();
        chk("imem_req_rise", 32'(imem_req), 32'd1);
        chk("first_fetch_addr", 32'(imem_addr), 32'd0);
        cyc = 1;
        while (!halted && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("A_cycles", 32'(cyc), 32'd16);
        chk("A_halted", 32'(halted), 32'd1);
        chk("A_pc_out", 32'(pc_out), 32'd4);
`ifdef NRISC_RETIRE_EN
        chk("A_instret", instret, 32'd4);
`endif
        repeat (3) tick();
        chk("A_halt_no_ireq", 32'(imem_req), 32'd0);
        chk("A_halt_no_dreq", 32'(dmem_req), 32'd0);
        chk("A_halt_pc", 32'(pc_out), 32'd4);
        chk("A_halt_sticky", 32'(halted), 32'd1);
        chk("W16_store", 32'(st16), 32'h0000_FFF8);
        chk("W16_halted", 32'(halted16), 32'd1);

        // Program A2: A plus SUB r1,r0 and stores of both registers
        clear_mem();
        rom[0] = 8'h43; rom[1] = 8'h5F; rom[2] = 8'h08; rom[3] = 8'h30;
        rom[4] = 8'h80; rom[5] = 8'h91;
        do_reset();
        run(200);
        chk("A2_cycles", 32'(cyc), 32'd28);
        chk("A2_r0", 32'(dram[0]), 32'h02);
        chk("A2_r1", 32'(dram[1]), 32'hFD);
`ifdef NRISC_RETIRE_EN
        chk("A2_instret", instret, 32'd7);
`endif

        // Program B: store then load through a 3-wait data memory
        clear_mem();
        rom[0] = 8'h45; rom[1] = 8'h85; rom[2] = 8'h75; rom[3] = 8'h96;
        dmem_wait = 3;
        do_reset();
        run(200);
        chk("B_cycles", 32'(cyc), 32'd30);
        chk("B_sw_mem5", 32'(dram[5]), 32'h05);
        chk("B_lw_r1", 32'(dram[6]), 32'h05);
`ifdef NRISC_RETIRE_EN
        chk("B_instret", instret, 32'd5);
`endif
        dmem_wait = 0;

        // Program C: BEQ taken/not taken at pc 7, J 31, 2-wait fetches
        clear_mem();
        rom[0] = 8'hC7; rom[7] = 8'hAE; rom[6] = 8'h41; rom[8] = 8'hDF; rom[31] = 8'h82;
        imem_wait = 2;
        do_reset();
        run(300);
        chk("C_cycles", 32'(cyc), 32'd38);
        chk("C_trace_len", 32'(ntr), 32'd7);
        chk("C_fetch1", 32'(trace[1]), 32'd7);
        chk("C_beq_taken", 32'(trace[2]), 32'd6);
        chk("C_beq_not_taken", 32'(trace[4]), 32'd8);
        chk("C_jump31", 32'(trace[5]), 32'd31);
        chk("C_store", 32'(dram[2]), 32'h01);
        chk("C_pc_out", 32'(pc_out), 32'd33);
`ifdef NRISC_RETIRE_EN
        chk("C_instret", instret, 32'd7);
`endif
        imem_wait = 0;

        // Program D: backward BEQ from 0 wraps to 0xFF, then fetch wraps to 0
        clear_mem();
        rom[0] = 8'hAE; rom[255] = 8'h51; rom[1] = 8'h93;
        do_reset();
        run(200);
        chk("D_cycles", 32'(cyc), 32'd18);
        chk("D_beq_wrap", 32'(trace[1]), 32'hFF);
        chk("D_pc_wrap", 32'(trace[2]), 32'h00);
        chk("D_fallthru", 32'(trace[3]), 32'h01);
        chk("D_store", 32'(dram[3]), 32'h01);

        // Program E: reset lands with a zero-wait load ack
        clear_mem();
        rom[0] = 8'h69;
        dram[9] = 8'h5A;
        do_reset();
        cyc = 0;
        while (!dmem_req && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("E_reached_mem", 32'(dmem_req), 32'd1);
        chk("E_pc_in_mem", 32'(pc_out), 32'd1);
        reset = 1'b1;
        tick();
        chk("E_dreq_drop", 32'(dmem_req), 32'd0);
        chk("E_pc_reset", 32'(pc_out), 32'd0);
        chk("E_ireq_low", 32'(imem_req), 32'd0);
        rom[0] = 8'h8A;
        reset = 1'b0;
        ntr = 0;
        run(100);
        chk("E_cycles", 32'(cyc), 32'd8);
        chk("E_r0_unchanged", 32'(dram[10]), 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nrisc_multiciclo.md
# nrisc_multiciclo

Multi-cycle, parametrised successor to the single-cycle 8-bit nRisc core. Executes the same 8-bit nRisc instruction encoding over a configurable data/PC width and talks to separate instruction and data memories through req/ack handshakes, so memories with wait states are supported. Sits at the top of the processor datapath, between the instruction ROM and the data RAM models.

## Interface
- DATA_W, 8, datapath/register/data-memory width (≥ 5)
- PC_W, 8, program counter and instruction address width (≥ 5)
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address (= pc)
- imem_rdata  in  8  instruction word, valid when imem_ack=1
- imem_ack  in  1  fetch complete
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  DATA_W  zero-extended imm4
- dmem_wdata  out  DATA_W  register ra value
- dmem_rdata  in  DATA_W  load data, valid when dmem_ack=1
- dmem_ack  in  1  data access complete
- halted  out  1  core stopped on HALT
- pc_out  out  PC_W  current pc

## Operation
- Encoding: op=[7:5], ra=[4], rb=[3], imm4=[3:0], imm3=[2:0], imm5=[4:0]. Two registers r0/r1, DATA_W bits.
- 000 ADD ra←ra+rb; 001 SUB ra←ra−rb; 010 ADDI ra←ra+sext(imm4); 011 LW ra←mem[zext(imm4)]; 100 SW mem[zext(imm4)]←ra; 101 BEQ if ra==rb pc←pc+sext(imm3); 110 J pc←zext(imm5); 111 HALT.
- Arithmetic modulo 2^DATA_W, no flags. PC arithmetic modulo 2^PC_W. BEQ offset is relative to already-incremented pc (pc of BEQ +1).
- FSM: FETCH, DECODE, EXEC, MEM, WB, HALT.
  - FETCH: imem_req=1; on imem_ack latch instruction, pc←pc+1, →DECODE.
  - DECODE: latch A=reg[ra], B=reg[rb] →EXEC.
  - EXEC: ADD/SUB/ADDI compute result →WB; LW/SW →MEM; BEQ/J update pc →FETCH; HALT →HALT.
  - MEM: dmem_req=1, dmem_we=(SW); on dmem_ack: LW latches rdata →WB; SW →FETCH.
  - WB: reg[ra]←result →FETCH.
  - HALT: absorbing; halted=1; no requests. Only reset exits.
- Handshake: req asserted from state entry and held, with addr/we/wdata stable, until ack sampled high; ack in the first req cycle = zero-wait. Ack while req=0 is ignored.

## Timing
- Reset values: pc=0, r0=r1=0, state=FETCH, imem_req=0, dmem_req=0, dmem_we=0, halted=0, pc_out=0, dmem_addr/dmem_wdata=0. imem_req rises the cycle after reset deasserts.
- Zero-wait cycle counts: ADD/SUB/ADDI 4, LW 5, SW 4, BEQ 3, J 3. Each memory wait cycle adds one.
- Register write visible to the next instruction's DECODE (no hazards; strictly sequential).
- Reset mid-access: request drops next cycle, outstanding ack ignored, no register/pc update from the aborted instruction.
- pc wraps 2^PC_W−1 → 0 on fetch; BEQ target wraps both directions.

## Configuration
- NRISC_RETIRE_EN defined: adds ports retire (out, 1, one-cycle pulse on the final cycle of every completed instruction: WB, SW ack, BEQ/J EXEC; HALT pulses once on entry) and instret (out, 32, retired-instruction count, reset 0, wraps).
- Undefined: ports and counter absent; all other behaviour identical.

## Test plan
- Reset then program ADDI r0,3; ADDI r1,−1; ADD r0,r1; HALT, zero-wait -> r0=2, r1=0xFF (DATA_W=8), halted=1 after 4+4+4+3 cycles, pc_out=4.
- SW r0 to addr 5 then LW r1 from 5 with 3-cycle dmem wait -> dmem_addr=5 held stable across waits, r1 equals r0, LW takes 8 cycles.
- BEQ r0,r1,−2 with r0==r1 at pc=7 -> next fetch at 6; with r0≠r1 -> fetch at 8; J 31 -> fetch at 31.
- pc=0xFF (PC_W=8), non-branch instruction -> next fetch address 0x00.
- Assert reset during MEM with dmem_req high, ack arriving same cycle -> register unchanged, pc=0, dmem_req=0 next cycle.
- DATA_W=16: ADDI r0,−8 from 0 -> r0=0xFFF8; NRISC_RETIRE_EN build -> instret increments once per instruction, retire never high two cycles in a row.
